// File: rtl/ysyx_23060061_axil_sram.sv
// ysyx_23060061_axil_sram: AXI4-Lite SRAM slave backed by an internal word array.
//   Independent read and write channels, each with one transaction in flight.
//   Minimum latencies are RD_LAT / WR_LAT cycles. An 8-bit LFSR can add extra delay
//   (masked by MAX_JITTER). Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH words)
//   return SLVERR; such writes are dropped and such reads return zero data.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
module ysyx_23060061_axil_sram #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DEPTH      = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter int unsigned        RD_LAT     = 2,
  parameter int unsigned        WR_LAT     = 1,
  parameter int unsigned        MAX_JITTER = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 16;
  localparam logic [7:0]  JMASK  = 8'(MAX_JITTER);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_WAIT, W_RESP} w_state_e;

  // Address decode helpers; the low byte-offset bits are dropped by the shift.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> OFF_W) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  r_state_e           r_state_q, r_state_d;
  logic [ADDR_W-1:0]  ar_addr_q, ar_addr_d;
  logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;

  w_state_e           w_state_q, w_state_d;
  logic [ADDR_W-1:0]  aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic [STRB_W-1:0]  w_strb_q, w_strb_d;
  logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;

  logic [7:0]         lfsr_q, lfsr_d;

  logic [7:0]         jitter_c;
  logic               r_in_range_c, w_in_range_c;
  logic [DATA_W-1:0]  rd_word_c;
  logic               aw_hs_c, w_hs_c, have_a_c, have_d_c, mem_we_c;

  // Fibonacci LFSR, taps 8,6,5,4; free-running.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign jitter_c = lfsr_q & JMASK;

  assign r_in_range_c = in_range(ar_addr_q);
  assign w_in_range_c = in_range(aw_addr_q);
  assign rd_word_c    = mem_q[word_idx(ar_addr_q)];
  assign aw_hs_c      = awvalid && awready_q;
  assign w_hs_c       = wvalid && wready_q;
  // Commit happens on the same edge that raises bvalid.
  assign mem_we_c     = (w_state_q == W_WAIT) && (w_cnt_q == '0) && w_in_range_c;

  // Read channel next-state.
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    r_cnt_d   = r_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          ar_addr_d = araddr;
          arready_d = 1'b0;
          r_cnt_d   = CNT_W'(RD_LAT - 1) + CNT_W'(jitter_c);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rdata_d   = r_in_range_c ? rd_word_c : '0;
          rresp_d   = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel next-state; AW and W are captured independently.
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_cnt_d   = w_cnt_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    have_a_c  = 1'b0;
    have_d_c  = 1'b0;
    unique case (w_state_q)
      W_IDLE, W_HAVE_A, W_HAVE_D: begin
        if (aw_hs_c) begin
          aw_addr_d = awaddr;
          awready_d = 1'b0;
        end
        if (w_hs_c) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          wready_d = 1'b0;
        end
        have_a_c = (w_state_q == W_HAVE_A) || aw_hs_c;
        have_d_c = (w_state_q == W_HAVE_D) || w_hs_c;
        if (have_a_c && have_d_c) begin
          w_cnt_d   = CNT_W'(WR_LAT - 1) + CNT_W'(jitter_c);
          w_state_d = W_WAIT;
        end else if (have_a_c) begin
          w_state_d = W_HAVE_A;
        end else if (have_d_c) begin
          w_state_d = W_HAVE_D;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range_c ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_cnt_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      lfsr_q    <= 8'hE1;
    end else begin
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Storage array, not reset; a read sampled on the commit edge sees old data.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_strb_q[b]) mem_q[word_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_23060061_axil_sram.sv
module tb_ysyx_23060061_axil_sram;

  localparam int unsigned DEPTH0 = 256;
  localparam int unsigned DEPTH1 = 16;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];
  logic [31:0] awaddr [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: fixed latency; instance 1: jitter enabled.
  ysyx_23060061_axil_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH0), .BASE_ADDR(BASE),
                            .RD_LAT(2), .WR_LAT(1), .MAX_JITTER(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]));

  ysyx_23060061_axil_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH1), .BASE_ADDR(BASE),
                            .RD_LAT(2), .WR_LAT(1), .MAX_JITTER(7)) u_dut1 (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]));

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [1:0]  resp;
    int          t0;
    int          lo;
    int          hi;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  int   checks = 0;
  int   errors = 0;
  int   max_jr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_r, input int d, input logic [31:0] data,
                      input logic [1:0] resp, input int lo, input int hi);
    exp_t e;
    e.dut = d; e.data = data; e.resp = resp; e.t0 = cyc; e.lo = lo; e.hi = hi;
    if (is_r) rq.push_back(e);
    else      bq.push_back(e);
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Wait until the selected slave has no transaction in flight.
  task automatic wait_idle(input int d);
    bit idle = 1'b0;
    int n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      idle = arready[d] && awready[d] && wready[d] && !rvalid[d] && !bvalid[d];
      n++;
    end
    if (!idle) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic rd(input int d, input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] resp, input int lo, input int hi, input bit wait_done);
    bit hs = 1'b0;
    int n = 0;
    araddr[d]  = addr;
    arvalid[d] = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = arready[d];
      @(posedge clk); #1;
      n++;
    end
    arvalid[d] = 1'b0;
    if (!hs) begin
      timeout("ar_handshake");
      return;
    end
    push(1'b1, d, data, resp, lo, hi);
    if (wait_done) wait_idle(d);
  endtask

  // W is presented first; AW follows aw_delay cycles later.
  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int aw_delay, input logic [1:0] resp,
                    input int lo, input int hi, input bit wait_done);
    bit ad = 1'b0, wd = 1'b0, ah, wh;
    int k = 0;
    awaddr[d] = addr;
    wdata[d]  = data;
    wstrb[d]  = strb;
    wvalid[d] = 1'b1;
    while (!(ad && wd) && k < 200) begin
      if (k == aw_delay) awvalid[d] = 1'b1;
      @(negedge clk);
      ah = awvalid[d] && awready[d];
      wh = wvalid[d] && wready[d];
      @(posedge clk); #1;
      if (ah) begin ad = 1'b1; awvalid[d] = 1'b0; end
      if (wh) begin wd = 1'b1; wvalid[d] = 1'b0; end
      k++;
    end
    if (!(ad && wd)) begin
      awvalid[d] = 1'b0;
      wvalid[d]  = 1'b0;
      timeout("aw_w_capture");
      return;
    end
    push(1'b0, d, 32'h0, resp, lo, hi);
    if (wait_done) wait_idle(d);
  endtask

  // Monitor: measures valid-rise latency and checks each accepted response.
  initial begin
    int   rrise[2], brise[2], lat;
    logic rprev[2], bprev[2];
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rrise[d] = 0; brise[d] = 0; rprev[d] = 1'b0; bprev[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rvalid[d] && !rprev[d]) rrise[d] = cyc;
        if (bvalid[d] && !bprev[d]) brise[d] = cyc;
        rprev[d] = rvalid[d];
        bprev[d] = bvalid[d];
        if (rvalid[d] && rready[d]) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: dut%0d got a read response, expected none", d);
          end else begin
            e   = rq.pop_front();
            lat = rrise[d] - e.t0;
            chk("r_dut", d, e.dut);
            chk("rdata", rdata[d], e.data);
            chk("rresp", 32'(rresp[d]), 32'(e.resp));
            checks++;
            if (lat < e.lo || lat > e.hi) begin
              errors++;
              $display("FAIL r_latency: got %0d expected %0d..%0d", lat, e.lo, e.hi);
            end
            if (d == 1 && lat > max_jr) max_jr = lat;
          end
        end
        if (bvalid[d] && bready[d]) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: dut%0d got a write response, expected none", d);
          end else begin
            e   = bq.pop_front();
            lat = brise[d] - e.t0;
            chk("b_dut", d, e.dut);
            chk("bresp", 32'(bresp[d]), 32'(e.resp));
            checks++;
            if (lat < e.lo || lat > e.hi) begin
              errors++;
              $display("FAIL b_latency: got %0d expected %0d..%0d", lat, e.lo, e.hi);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] jmodel[DEPTH1];
    logic [31:0] dat;
    logic [3:0]  stb;
    int          idx, n;

    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b1;
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
      wvalid[d] = 1'b0; bready[d] = 1'b1;
    end

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(arready[0]), 32'd1);
    chk("rst_awready", 32'(awready[0]), 32'd1);
    chk("rst_wready",  32'(wready[0]),  32'd1);
    chk("rst_rvalid",  32'(rvalid[0]),  32'd0);
    chk("rst_bvalid",  32'(bvalid[0]),  32'd0);
    chk("rst_rdata",   rdata[0],        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then read-back.
    wr(0, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, OKAY, 1, 1, 1'b1);
    rd(0, BASE + 32'h4, 32'hDEAD_BEEF, OKAY, 2, 2, 1'b1);
    rd(0, BASE + 32'h6, 32'hDEAD_BEEF, OKAY, 2, 2, 1'b1);

    // Decoupled write: W three cycles ahead of AW; memory must keep the old word meanwhile.
    wr(0, BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 0, OKAY, 1, 1, 1'b1);
    fork
      wr(0, BASE + 32'h8, 32'h1234_5678, 4'hF, 3, OKAY, 1, 1, 1'b1);
      begin
        @(posedge clk); #1;
        chk("dec_wready_low",  32'(wready[0]),  32'd0);
        chk("dec_awready_high", 32'(awready[0]), 32'd1);
        rd(0, BASE + 32'h8, 32'hCAFE_F00D, OKAY, 2, 2, 1'b1);
      end
    join
    rd(0, BASE + 32'h8, 32'h1234_5678, OKAY, 2, 2, 1'b1);

    // Byte strobes.
    wr(0, BASE + 32'h10, 32'h1122_3344, 4'hF, 0, OKAY, 1, 1, 1'b1);
    wr(0, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 0, OKAY, 1, 1, 1'b1);
    rd(0, BASE + 32'h10, 32'h11BB_33DD, OKAY, 2, 2, 1'b1);

    // Out of range on both sides of the window.
    rd(0, 32'h7FFF_FFFC, 32'h0, SLVERR, 2, 2, 1'b1);
    wr(0, BASE, 32'h0BAD_CAFE, 4'hF, 0, OKAY, 1, 1, 1'b1);
    wr(0, BASE + 32'(4 * (DEPTH0 - 1)), 32'h5A5A_5A5A, 4'hF, 0, OKAY, 1, 1, 1'b1);
    wr(0, BASE + 32'(4 * DEPTH0), 32'hFFFF_FFFF, 4'hF, 0, SLVERR, 1, 1, 1'b1);
    rd(0, BASE + 32'(4 * (DEPTH0 - 1)), 32'h5A5A_5A5A, OKAY, 2, 2, 1'b1);
    rd(0, BASE, 32'h0BAD_CAFE, OKAY, 2, 2, 1'b1);
    rd(0, BASE + 32'(4 * DEPTH0), 32'h0, SLVERR, 2, 2, 1'b1);

    // Read backpressure: response must hold while rready is low.
    rready[0] = 1'b0;
    rd(0, BASE + 32'h4, 32'hDEAD_BEEF, OKAY, 2, 2, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid[0] && n < 50);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 32'(rvalid[0]), 32'd1);
      chk("bp_rdata",  rdata[0],       32'hDEAD_BEEF);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready[0] = 1'b1;
    wait_idle(0);

    // Read sample and write commit on the same edge: read sees old data.
    wr(0, BASE + 32'h20, 32'h0101_0101, 4'hF, 0, OKAY, 1, 1, 1'b1);
    araddr[0] = BASE + 32'h20; arvalid[0] = 1'b1;
    @(posedge clk); #1;
    arvalid[0] = 1'b0;
    push(1'b1, 0, 32'h0101_0101, OKAY, 2, 2);
    awaddr[0] = BASE + 32'h20; wdata[0] = 32'h0202_0202; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    push(1'b0, 0, 32'h0, OKAY, 1, 1);
    wait_idle(0);
    rd(0, BASE + 32'h20, 32'h0202_0202, OKAY, 2, 2, 1'b1);

    // Reset during W_WAIT aborts the write.
    wr(0, BASE + 32'h30, 32'h7777_7777, 4'hF, 0, OKAY, 1, 1, 1'b1);
    awaddr[0] = BASE + 32'h30; wdata[0] = 32'h8888_8888; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bvalid",  32'(bvalid[0]),  32'd0);
    chk("abort_awready", 32'(awready[0]), 32'd1);
    chk("abort_wready",  32'(wready[0]),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_bvalid_after", 32'(bvalid[0]), 32'd0);
    @(posedge clk); #1;
    rd(0, BASE + 32'h30, 32'h7777_7777, OKAY, 2, 2, 1'b1);

    // Jittered instance: fill, then random traffic against a model.
    for (int i = 0; i < int'(DEPTH1); i++) begin
      dat = 32'h1000_0000 + 32'(i);
      jmodel[i] = dat;
      wr(1, BASE + 32'(4 * i), dat, 4'hF, 0, OKAY, 1, 8, 1'b1);
    end
    for (int t = 0; t < 1000; t++) begin
      idx = int'($urandom_range(0, DEPTH1 - 1));
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        stb = 4'($urandom_range(1, 15));
        for (int b = 0; b < 4; b++) if (stb[b]) jmodel[idx][8*b +: 8] = dat[8*b +: 8];
        wr(1, BASE + 32'(4 * idx), dat, stb, int'($urandom_range(0, 2)), OKAY, 1, 8, 1'b1);
      end else begin
        rd(1, BASE + 32'(4 * idx), jmodel[idx], OKAY, 2, 9, 1'b1);
      end
    end

    repeat (3) @(posedge clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("jitter_seen", 32'(max_jr > 2), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
